// File: rtl/pong_pkg.sv
// Shared Pong definitions: screen and paddle geometry (kept common so the renderer and the
// paddle controller agree), the 10-bit screen coordinate type and the paddle FSM states.
package pong_pkg;

  localparam int unsigned SCREEN_WIDTH  = 640;
  localparam int unsigned SCREEN_HEIGHT = 480;
  localparam int unsigned PADDLE_HEIGHT = 50;
  localparam int unsigned PADDLE_WIDTH  = 10;
  localparam int unsigned PADDLE_MARGIN = 20;

  typedef logic [9:0] coord_t;

  typedef enum logic [0:0] {
    StPlay,
    StFreeze
  } paddle_state_e;

endpackage

// File: rtl/paddle_axis.sv
// One paddle axis: button synchroniser, per-frame step with clamping, and the position
// register.
//   clk_i, rst_i     clock, synchronous active-high reset
//   up_i, down_i     raw (asynchronous) buttons, or already-synchronous levels when SyncEn=0
//   step_en_i        apply one movement step on this edge
//   recenter_i       force the position to YCenter (wins over step_en_i)
//   pos_o            registered paddle top Y
module paddle_axis
  import pong_pkg::*;
#(
  parameter int unsigned Speed   = 4,
  parameter int unsigned YMax    = 430,
  parameter int unsigned YCenter = 215,
  parameter bit          SyncEn  = 1'b1
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   up_i,
  input  logic   down_i,
  input  logic   step_en_i,
  input  logic   recenter_i,
  output coord_t pos_o
);

  localparam logic [10:0] SpeedW = 11'(Speed);
  localparam logic [10:0] YMaxW  = 11'(YMax);

  logic        up_s, down_s;
  coord_t      pos_q;
  logic [10:0] pos_w, sum_w;

  generate
    if (SyncEn) begin : g_sync
      logic [1:0] up_q, down_q;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          up_q   <= '0;
          down_q <= '0;
        end else begin
          up_q   <= {up_q[0], up_i};
          down_q <= {down_q[0], down_i};
        end
      end
      assign up_s   = up_q[1];
      assign down_s = down_q[1];
    end else begin : g_nosync
      assign up_s   = up_i;
      assign down_s = down_i;
    end
  endgenerate

  // 11-bit arithmetic so the downward sum can never wrap before the clamp.
  assign pos_w = {1'b0, pos_q};
  assign sum_w = pos_w + SpeedW;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pos_q <= coord_t'(YCenter);
    end else if (recenter_i) begin
      pos_q <= coord_t'(YCenter);
    end else if (step_en_i) begin
      if (up_s && !down_s) begin
        pos_q <= (pos_w < SpeedW) ? '0 : coord_t'(pos_w - SpeedW);
      end else if (down_s && !up_s) begin
        pos_q <= (sum_w > YMaxW) ? coord_t'(YMax) : coord_t'(sum_w);
      end
    end
  end

  assign pos_o = pos_q;

endmodule

// File: rtl/paddle_controller.sv
// Paddle controller: owns both paddle Y positions, moves them once per video frame from
// the player buttons, clamps them to the screen and freezes/re-centres them after a point.
//   i_clk, i_reset          pixel clock, synchronous active-high reset
//   i_frame_tick            vertical-blank level; its rising edge is the frame strobe
//   i_p1_up .. i_p2_down    asynchronous player buttons
//   i_point_scored          one-cycle pulse from the ball logic
//   i_ball_y                ball Y, used only when PADDLE_AI_P2_EN is defined
//   o_y_paddle1/2_pos       registered paddle top Y
//   o_frozen                high while in the post-point freeze
// Build option: define PADDLE_AI_P2_EN to let paddle 2 track the ball instead of player 2.
module paddle_controller
  import pong_pkg::*;
#(
  parameter int unsigned PADDLE_HEIGHT = pong_pkg::PADDLE_HEIGHT,
  parameter int unsigned SCREEN_HEIGHT = pong_pkg::SCREEN_HEIGHT,
  parameter int unsigned PADDLE_SPEED  = 4,
  parameter int unsigned FREEZE_FRAMES = 60
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_frame_tick,
  input  logic       i_p1_up,
  input  logic       i_p1_down,
  input  logic       i_p2_up,
  input  logic       i_p2_down,
  input  logic       i_point_scored,
  input  logic [9:0] i_ball_y,
  output logic [9:0] o_y_paddle1_pos,
  output logic [9:0] o_y_paddle2_pos,
  output logic       o_frozen
);

  localparam int unsigned Y_MAX    = SCREEN_HEIGHT - PADDLE_HEIGHT;
  localparam int unsigned Y_CENTER = (SCREEN_HEIGHT - PADDLE_HEIGHT) / 2;
  localparam int unsigned CntW     = $clog2(FREEZE_FRAMES + 1);

  paddle_state_e   state_q;
  logic [CntW-1:0] cnt_q;
  logic            frozen_q;
  logic            tick_d;
  logic            frame_stb;
  logic            step_en;
  coord_t          pos1, pos2;
  logic            p2_up, p2_down;

  assign frame_stb = i_frame_tick & ~tick_d;
  // A score in the strobe cycle wins: recentre instead of moving.
  assign step_en   = (state_q == StPlay) & frame_stb & ~i_point_scored;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= StPlay;
      cnt_q    <= '0;
      frozen_q <= 1'b0;
      tick_d   <= 1'b0;
    end else begin
      tick_d <= i_frame_tick;
      unique case (state_q)
        StPlay: begin
          if (i_point_scored) begin
            state_q  <= StFreeze;
            cnt_q    <= CntW'(FREEZE_FRAMES - 1);
            frozen_q <= 1'b1;
          end
        end
        StFreeze: begin
          if (i_point_scored) begin
            cnt_q <= CntW'(FREEZE_FRAMES - 1);
          end else if (frame_stb) begin
            if (cnt_q == '0) begin
              state_q  <= StPlay;
              frozen_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
        default: state_q <= StPlay;
      endcase
    end
  end

`ifdef PADDLE_AI_P2_EN
  // Paddle 2 chases the ball centre; the dead band of +-speed/2 stops it dithering.
  localparam logic [10:0] HalfH = 11'(PADDLE_HEIGHT / 2);
  localparam logic [10:0] HalfS = 11'(PADDLE_SPEED / 2);
  logic [10:0] ball_w, target, pos2_w;
  logic        unused_p2_buttons;

  assign ball_w            = {1'b0, i_ball_y};
  assign pos2_w            = {1'b0, pos2};
  assign target            = (ball_w >= HalfH) ? ball_w - HalfH : '0;
  assign p2_down           = (pos2_w + HalfS) < target;
  assign p2_up             = pos2_w > (target + HalfS);
  assign unused_p2_buttons = i_p2_up ^ i_p2_down;
  localparam bit P2Sync = 1'b0;
`else
  logic unused_ball_y;
  assign p2_up         = i_p2_up;
  assign p2_down       = i_p2_down;
  assign unused_ball_y = ^i_ball_y;
  localparam bit P2Sync = 1'b1;
`endif

  paddle_axis #(
    .Speed  (PADDLE_SPEED),
    .YMax   (Y_MAX),
    .YCenter(Y_CENTER),
    .SyncEn (1'b1)
  ) u_axis1 (
    .clk_i     (i_clk),
    .rst_i     (i_reset),
    .up_i      (i_p1_up),
    .down_i    (i_p1_down),
    .step_en_i (step_en),
    .recenter_i(i_point_scored),
    .pos_o     (pos1)
  );

  paddle_axis #(
    .Speed  (PADDLE_SPEED),
    .YMax   (Y_MAX),
    .YCenter(Y_CENTER),
    .SyncEn (P2Sync)
  ) u_axis2 (
    .clk_i     (i_clk),
    .rst_i     (i_reset),
    .up_i      (p2_up),
    .down_i    (p2_down),
    .step_en_i (step_en),
    .recenter_i(i_point_scored),
    .pos_o     (pos2)
  );

  assign o_y_paddle1_pos = pos1;
  assign o_y_paddle2_pos = pos2;
  assign o_frozen        = frozen_q;

endmodule

// File: tb/tb_paddle_controller.sv
module tb_paddle_controller;

  localparam int YMAX   = 430;
  localparam int YCEN   = 215;
  localparam int SPEED  = 4;
  localparam int FREEZE = 60;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       p1u = 1'b0, p1d = 1'b0, p2u = 1'b0, p2d = 1'b0;
  logic       pt = 1'b0;
  logic [9:0] ball = 10'd0;
  logic [9:0] y1, y2;
  logic       frz;

  paddle_controller dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_frame_tick   (tick),
    .i_p1_up        (p1u),
    .i_p1_down      (p1d),
    .i_p2_up        (p2u),
    .i_p2_down      (p2d),
    .i_point_scored (pt),
    .i_ball_y       (ball),
    .o_y_paddle1_pos(y1),
    .o_y_paddle2_pos(y2),
    .o_frozen       (frz)
  );

  always #5 clk = ~clk;

  typedef struct {
    int p1;
    int p2;
    bit fr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int m_p1 = YCEN, m_p2 = YCEN, m_left = 0;
  bit m_frozen = 1'b0;

  function automatic int step(input int pos, input bit up, input bit dn);
    if (up && !dn) return (pos - SPEED < 0) ? 0 : pos - SPEED;
    if (dn && !up) return (pos + SPEED > YMAX) ? YMAX : pos + SPEED;
    return pos;
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.p1 = m_p1;
    e.p2 = m_p2;
    e.fr = m_frozen;
    exp_q.push_back(e);
  endfunction

  function automatic void model_reset();
    m_p1 = YCEN; m_p2 = YCEN; m_frozen = 1'b0; m_left = 0;
  endfunction

  function automatic void model_point();
    m_p1 = YCEN; m_p2 = YCEN; m_frozen = 1'b1; m_left = FREEZE;
  endfunction

  function automatic void model_frame(input bit u1, d1, u2, d2, input int by);
    if (m_frozen) begin
      m_left--;
      if (m_left == 0) m_frozen = 1'b0;
    end else begin
      m_p1 = step(m_p1, u1, d1);
`ifdef PADDLE_AI_P2_EN
      begin
        int tgt;
        tgt = (by - 25 < 0) ? 0 : by - 25;
        m_p2 = step(m_p2, (m_p2 > tgt + SPEED / 2), (m_p2 < tgt - SPEED / 2));
      end
`else
      m_p2 = step(m_p2, u2, d2);
`endif
    end
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: an output event is any edge with reset, a score pulse or a rising frame tick.
  // Between events the outputs must hold the last expected value.
  initial begin : monitor
    bit   ev, tick_prev, have;
    exp_t e, last;
    tick_prev = 1'b0;
    have      = 1'b0;
    forever begin
      @(posedge clk);
      ev        = rst || pt || (tick && !tick_prev);
      tick_prev = tick;
      @(negedge clk);
      if (ev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: output event with no expectation at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("pos1", int'(y1), e.p1);
          chk("pos2", int'(y2), e.p2);
          chk("frozen", int'(frz), int'(e.fr));
          last = e;
          have = 1'b1;
        end
      end else if (have) begin
        chk("pos1_hold", int'(y1), last.p1);
        chk("pos2_hold", int'(y2), last.p2);
        chk("frozen_hold", int'(frz), int'(last.fr));
      end
    end
  end

  task automatic do_reset(input int n);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < n; i++) begin
      push_exp();
      @(posedge clk);
    end
    #1 rst = 1'b0;
  endtask

  // One video frame. ptmode: 0 none, 1 score mid-frame, 2 score coincident with the strobe.
  // glitch: buttons pulse randomly first, then settle to the requested levels.
  task automatic run_frame(input bit u1, d1, u2, d2, input int ptmode, input bit glitch,
                           input int by);
    @(posedge clk);
    #1;
    ball = 10'(by);
    if (glitch) begin
      {p1u, p1d, p2u, p2d} = 4'($urandom);
      repeat (3) @(posedge clk);
      #1;
    end
    p1u = u1; p1d = d1; p2u = u2; p2d = d2;
    repeat (4) @(posedge clk);
    #1;
    if (ptmode == 1) begin
      pt = 1'b1;
      model_point();
      push_exp();
      @(posedge clk);
      #1 pt = 1'b0;
      repeat (3) @(posedge clk);
      #1;
    end
    tick = 1'b1;
    if (ptmode == 2) begin
      pt = 1'b1;
      model_point();
    end else begin
      model_frame(u1, d1, u2, d2, by);
    end
    push_exp();
    @(posedge clk);
    #1 pt = 1'b0;
    repeat (2) @(posedge clk);
    #1 tick = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin : stim
    do_reset(2);
    repeat (3) run_frame(0, 0, 0, 0, 0, 0, 200);
    repeat (10) run_frame(1, 0, 0, 0, 0, 0, 400);   // P1 -> 175
    repeat (50) run_frame(1, 0, 0, 1, 0, 0, 400);   // P1 clamps at 0
    repeat (20) run_frame(0, 0, 0, 1, 0, 0, 400);   // P2 clamps at 430
    repeat (5) run_frame(1, 1, 0, 0, 0, 0, 400);    // both held: hold
    run_frame(0, 0, 0, 0, 0, 1, 400);               // pulse gone before strobe
    repeat (2) run_frame(1, 0, 0, 0, 0, 0, 10);
    run_frame(1, 0, 0, 1, 1, 0, 10);                // score with P1 at 0
    repeat (60) run_frame(1, 0, 0, 1, 0, 0, 10);    // frozen for 60 strobes
    run_frame(1, 0, 0, 1, 0, 0, 10);                // P1 -> 211
    run_frame(0, 1, 1, 0, 2, 0, 10);                // score coincident with strobe
    repeat (29) run_frame(0, 1, 1, 0, 0, 0, 10);
    run_frame(0, 1, 1, 0, 1, 0, 10);                // rescore extends freeze
    repeat (61) run_frame(0, 1, 1, 0, 0, 0, 10);
    repeat (5) run_frame(0, 1, 1, 0, 0, 0, 10);
    @(posedge clk);
    #1;
    do_reset(1);                                    // mid-run reset
    for (int f = 0; f < 250; f++) begin
      int r, mode;
      r    = int'($urandom_range(0, 99));
      mode = (r < 3) ? 1 : (r < 5) ? 2 : 0;
      run_frame(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), mode,
                ($urandom_range(0, 7) == 0), int'($urandom_range(0, 479)));
    end
    repeat (5) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/paddle_controller.md
Name: paddle_controller

Overview:
- Owns the two paddle Y positions consumed by the paddle renderer (`i_y_paddle1_pos` / `i_y_paddle2_pos`).
- Synchronises the player up/down buttons and moves each paddle once per video frame.
- Clamps each paddle to the visible screen.
- Runs a small FSM that freezes and re-centres both paddles after a point is scored.

Parameters:
- PADDLE_HEIGHT, 50, paddle height in pixels; must match the renderer.
- SCREEN_HEIGHT, 480, visible lines.
- PADDLE_SPEED, 4, pixels moved per frame while a button is held.
- FREEZE_FRAMES, 60, frames held in FREEZE after a point.
- Y_MAX, SCREEN_HEIGHT-PADDLE_HEIGHT (derived localparam), highest legal position, 430.
- Y_CENTER, (SCREEN_HEIGHT-PADDLE_HEIGHT)/2 (derived localparam), reset and re-centre position, 215.

Ports:
- i_clk  input  1  pixel clock.
- i_reset  input  1  synchronous, active-high reset.
- i_frame_tick  input  1  level, high during vertical blanking; the controller edge-detects it.
- i_p1_up  input  1  async button, player 1 up.
- i_p1_down  input  1  async button, player 1 down.
- i_p2_up  input  1  async button, player 2 up.
- i_p2_down  input  1  async button, player 2 down.
- i_point_scored  input  1  one-cycle pulse from the ball logic.
- i_ball_y  input  10  ball Y position; used only with the optional feature.
- o_y_paddle1_pos  output  10  paddle 1 top Y.
- o_y_paddle2_pos  output  10  paddle 2 top Y.
- o_frozen  output  1  high while in FREEZE.

Behaviour:
- One clock, i_clk. Reset is synchronous and active-high: i_reset is sampled on the rising edge of i_clk.
- Reset values:
  - o_y_paddle1_pos = Y_CENTER
  - o_y_paddle2_pos = Y_CENTER
  - o_frozen = 0
  - FSM = PLAY
  - freeze counter = 0
  - all synchroniser flops and the frame-edge flop = 0
- Buttons: each passes through a 2-flop synchroniser. Sampled value is the second flop.
- Frame strobe: `frame_stb = i_frame_tick & ~tick_d`, where tick_d is i_frame_tick registered. Exactly one strobe cycle per frame.
- Position updates happen only in the cycle after frame_stb, so outputs change at most once per frame and are stable through the visible area.
- Movement, per paddle, in PLAY on frame_stb:
  - up=1, down=0 → `pos = (pos < PADDLE_SPEED) ? 0 : pos - PADDLE_SPEED`.
  - down=1, up=0 → `pos = (pos + PADDLE_SPEED > Y_MAX) ? Y_MAX : pos + PADDLE_SPEED`.
  - up=down=1, or neither → hold.
  - Compute the sum in 11 bits; no wrap-around is permitted.
- FSM states: PLAY, FREEZE.
  - PLAY → FREEZE on i_point_scored:
    - load counter = FREEZE_FRAMES-1;
    - both positions ← Y_CENTER on the next edge;
    - o_frozen=1 from the next cycle.
    - If i_point_scored and frame_stb coincide, the freeze wins; no movement is applied.
  - FREEZE: buttons are ignored. On each frame_stb, if counter==0 go to PLAY (o_frozen=0), else decrement.
  - i_point_scored while in FREEZE reloads the counter to FREEZE_FRAMES-1.
  - The first frame_stb in FREEZE counts as a frame.
- i_reset mid-operation overrides everything, including a pending freeze, and restores the reset values next edge.
- Outputs are registered; they are never driven combinationally from inputs.

Optional Feature:
- Macro: PADDLE_AI_P2_EN.
- Defined: player 2 buttons are ignored. On frame_stb in PLAY, paddle 2 targets `i_ball_y - PADDLE_HEIGHT/2`, floored at 0.
  - If pos < target − PADDLE_SPEED/2, move down.
  - If pos > target + PADDLE_SPEED/2, move up.
  - Otherwise hold.
  - Same step size and clamping as manual movement.
- Undefined: i_ball_y is unused and player 2 is manual.
- Port list is identical in both builds.

Decomposition:
- Shared package pong_pkg holds:
  - SCREEN_WIDTH, SCREEN_HEIGHT, PADDLE_HEIGHT, PADDLE_WIDTH, PADDLE_MARGIN, so renderer and controller agree;
  - the 10-bit coordinate typedef;
  - the FSM state enum.
- One natural sub-module: paddle_axis.
  - Contents: synchroniser, step/clamp, and position register for one paddle.
  - Inputs: up, down, step_en, recenter.
  - Instantiated twice.
  - The FSM, frame-edge detect and AI target logic stay in the top.

Test Plan:
- Reset: assert i_reset 2 cycles → both positions 215, o_frozen=0, outputs unchanged for 3 frames with no buttons pressed.
- P1 up held 10 frames from 215 → 175; continue to 60 frames → clamps at 0, never wraps to 1020+. P2 down held 70 frames → clamps at 430.
- Both up and down held on P1 for 5 frames → position constant. Button pulse that ends before frame_stb → no movement.
- i_point_scored pulse with P1 at 0 → both positions 215 next cycle, o_frozen=1. Buttons held are ignored for exactly 60 frame strobes, then o_frozen=0 and P1 moves to 211 on the following strobe.
- i_point_scored coincident with frame_stb in PLAY → no movement, enters FREEZE. Second score at freeze frame 30 → freeze extends to 60 frames from that point.
- With PADDLE_AI_P2_EN, i_ball_y=400 → paddle 2 steps +4/frame from 215 until within ±2 of 375, then holds. i_ball_y=10 → paddle 2 converges to 0.
